// File: rtl/pre_if_fetch_queue.sv
// pre_if_fetch_queue: pre-IF fetch stage with up to OUTSTANDING in-flight
// inst_sram requests, an in-order instruction queue of BUF_DEPTH entries and a
// single redirect input that flushes the queue and drops stale responses.
module pre_if_fetch_queue #(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned BUF_DEPTH   = 4,
    parameter logic [31:0] RESET_PC    = 32'hbfc00000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               redirect_valid,
    input  logic [31:0]                        redirect_pc,
    input  logic                               fetch_stall,
    input  logic                               fs_allowin,
    output logic                               pfs_to_fs_valid,
    output logic [31:0]                        pfs_to_fs_pc,
    output logic [31:0]                        pfs_to_fs_inst,
    output logic                               inst_sram_req,
    output logic [31:0]                        inst_sram_addr,
    input  logic                               inst_sram_addr_ok,
    input  logic [31:0]                        inst_sram_rdata,
    input  logic                               inst_sram_data_ok,
    output logic [$clog2(OUTSTANDING+1)-1:0]   pfs_inflight_cnt,
    output logic                               pfs_inst_waiting
);

    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OW = $clog2(BUF_DEPTH + 1);

    localparam logic [CW-1:0] LP_OUT   = CW'(OUTSTANDING);
    localparam logic [OW-1:0] LP_DEPTH = OW'(BUF_DEPTH);
    localparam logic [PW-1:0] LP_LAST  = PW'(BUF_DEPTH - 1);

    // fetch state
    logic [31:0]          r_issue_pc;
    logic [CW-1:0]        r_live;
    logic [CW-1:0]        r_stale;

    // queue: rd = head, fill = oldest slot awaiting its word, rsv = next slot to reserve
    logic [OW-1:0]        r_occ;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_fill_ptr;
    logic [PW-1:0]        r_rsv_ptr;
    logic [BUF_DEPTH-1:0] r_q_vld;
    logic [31:0]          r_q_pc   [BUF_DEPTH];
    logic [31:0]          r_q_inst [BUF_DEPTH];

    logic [CW-1:0]        w_total;
    logic [CW-1:0]        w_redir_stale;
    logic                 w_req;
    logic                 w_hs;
    logic                 w_dok_stale;
    logic                 w_dok_live;
    logic                 w_head_vld;
    logic                 w_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LP_LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_total     = r_live + r_stale;
    assign w_req       = !reset && !redirect_valid && !fetch_stall &&
                         (w_total < LP_OUT) && (r_occ < LP_DEPTH);
    assign w_hs        = w_req && inst_sram_addr_ok;
    assign w_dok_stale = inst_sram_data_ok && (r_stale != '0);
    assign w_dok_live  = inst_sram_data_ok && (r_stale == '0) && (r_live != '0);
    assign w_head_vld  = r_q_vld[r_rd_ptr];
    assign w_pop       = w_head_vld && fs_allowin;

    // a response arriving in the redirect cycle belongs to the old stream
    assign w_redir_stale = w_total - CW'(inst_sram_data_ok && (w_total != '0));

    assign inst_sram_req    = w_req;
    assign inst_sram_addr   = {r_issue_pc[31:2], 2'b00};
    assign pfs_to_fs_valid  = w_head_vld;
    assign pfs_to_fs_pc     = w_head_vld ? r_q_pc[r_rd_ptr]   : '0;
    assign pfs_to_fs_inst   = w_head_vld ? r_q_inst[r_rd_ptr] : '0;
    assign pfs_inflight_cnt = w_total;
    assign pfs_inst_waiting = (r_live != '0) && !w_head_vld;

    // control state: issue pc, counters, pointers and per-entry valid bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_pc <= RESET_PC;
            r_live     <= '0;
            r_stale    <= '0;
            r_occ      <= '0;
            r_rd_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rsv_ptr  <= '0;
            r_q_vld    <= '0;
        end else if (redirect_valid) begin
            r_issue_pc <= redirect_pc;
            r_live     <= '0;
            r_stale    <= w_redir_stale;
            r_occ      <= '0;
            r_rd_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rsv_ptr  <= '0;
            r_q_vld    <= '0;
        end else begin
            if (w_hs) begin
                r_issue_pc <= r_issue_pc + 32'd4;
                r_rsv_ptr  <= f_next(r_rsv_ptr);
            end
            if (w_dok_stale) begin
                r_stale <= r_stale - CW'(1);
            end
            if (w_dok_live) begin
                r_q_vld[r_fill_ptr] <= 1'b1;
                r_fill_ptr          <= f_next(r_fill_ptr);
            end
            if (w_pop) begin
                r_q_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= f_next(r_rd_ptr);
            end
            case ({w_hs, w_dok_live})
                2'b10:   r_live <= r_live + CW'(1);
                2'b01:   r_live <= r_live - CW'(1);
                default: r_live <= r_live;
            endcase
            case ({w_hs, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // queue payload: pc captured at reservation, instruction at live response
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_q_pc[r_rsv_ptr] <= r_issue_pc;
        end
        if (w_dok_live && !redirect_valid) begin
            r_q_inst[r_fill_ptr] <= inst_sram_rdata;
        end
    end

endmodule
